// File: rtl/system_bus_pkg.sv
// Shared bus-width constants and RAM controller state type for the system bus RAM.
package system_bus_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_BE_WIDTH   = 4;

  typedef enum logic {
    RAM_CLEAR,
    RAM_ACTIVE
  } ram_state_t;

endpackage

// File: rtl/system_bus_ram_byte_enable_ram.sv
// Word-wide RAM with per-byte write enables and a registered (1-cycle) read port.
// Each byte lane is its own array so every lane maps cleanly onto block RAM.
module byte_enable_ram
  import system_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  input  logic [BUS_BE_WIDTH-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [BUS_DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  for (genvar gi = 0; gi < BUS_BE_WIDTH; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_lane_q;

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_addr] <= wr_data[8*gi +: 8];
      end
    end

    // Registered read; the register holds its value when no read is issued.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_lane_q <= '0;
      end else if (rd_en) begin
        rd_lane_q <= lane_mem[rd_addr];
      end
    end

    assign rd_data[8*gi +: 8] = rd_lane_q;
  end

endmodule

// File: rtl/system_bus_ram.sv
// System bus responder backed by a byte-enabled block RAM. After reset it can
// zero-fill the whole array while holding ready low, then serves one request per
// cycle with fixed-latency, fully pipelined reads.
module system_bus_ram
  import system_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      system_bus_ready,
  input  logic [BUS_ADDR_WIDTH-1:0] system_bus_addr,
  input  logic [BUS_DATA_WIDTH-1:0] system_bus_write_data,
  input  logic [BUS_BE_WIDTH-1:0]   system_bus_byte_enable,
  input  logic                      system_bus_write_req,
  input  logic                      system_bus_read_req,
  output logic [BUS_DATA_WIDTH-1:0] system_bus_read_data,
  output logic                      system_bus_read_data_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  ram_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [READ_LATENCY-1:0] valid_q, valid_d;

  logic                      accept_wr;
  logic                      accept_rd;
  logic                      in_clear;
  logic [ADDR_WIDTH-1:0]     bus_idx;
  logic                      ram_wr_en;
  logic [ADDR_WIDTH-1:0]     ram_wr_addr;
  logic [BUS_DATA_WIDTH-1:0] ram_wr_data;
  logic [BUS_BE_WIDTH-1:0]   ram_wr_be;
  logic [BUS_DATA_WIDTH-1:0] ram_rd_data;

  // Bits outside the word index are decoded upstream and deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{system_bus_addr[BUS_ADDR_WIDTH-1:ADDR_WIDTH+2],
                              system_bus_addr[1:0]};

  assign bus_idx  = system_bus_addr[ADDR_WIDTH+1:2];
  assign in_clear = (state_q == RAM_CLEAR);

  // A simultaneous read and write is treated as a write only.
  assign accept_wr = ready_q & system_bus_write_req;
  assign accept_rd = ready_q & system_bus_read_req & ~system_bus_write_req;

  // Clear-fill and bus writes share the RAM write port; they never overlap
  // because ready is low for the whole fill.
  always_comb begin
    ram_wr_en   = in_clear | accept_wr;
    ram_wr_addr = in_clear ? cnt_q : bus_idx;
    ram_wr_data = in_clear ? '0 : system_bus_write_data;
    ram_wr_be   = in_clear ? '1 : system_bus_byte_enable;
  end

  // Next-state for the fill sequencer; ready follows the state it is entering.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RAM_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RAM_ACTIVE;
        end
      end
      RAM_ACTIVE: begin
        state_d = RAM_ACTIVE;
      end
      default: begin
        state_d = RAM_ACTIVE;
      end
    endcase
    ready_d = (state_d == RAM_ACTIVE);
  end

  // Valid strobe travels one stage per cycle alongside its read.
  always_comb begin
    valid_d = READ_LATENCY'({valid_q, accept_rd});
  end

  // State, fill counter, ready and valid pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? RAM_CLEAR : RAM_ACTIVE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  byte_enable_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (ram_wr_en),
    .wr_addr(ram_wr_addr),
    .wr_data(ram_wr_data),
    .wr_be  (ram_wr_be),
    .rd_en  (accept_rd),
    .rd_addr(bus_idx),
    .rd_data(ram_rd_data)
  );

  if (READ_LATENCY == 1) begin : g_lat1
    // The RAM read register is already the output register.
    assign system_bus_read_data = ram_rd_data;
  end else begin : g_latn
    logic [READ_LATENCY-2:0][BUS_DATA_WIDTH-1:0] stage_q, stage_d;

    // Each stage only loads when a valid word is moving into it, so the
    // final stage holds its last value between strobes.
    always_comb begin
      stage_d = stage_q;
      if (valid_q[0]) begin
        stage_d[0] = ram_rd_data;
      end
      for (int k = 1; k < READ_LATENCY - 1; k++) begin
        if (valid_q[k]) begin
          stage_d[k] = stage_q[k-1];
        end
      end
    end

    // Output data pipeline registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign system_bus_read_data = stage_q[READ_LATENCY-2];
  end

  assign system_bus_ready           = ready_q;
  assign system_bus_read_data_valid = valid_q[READ_LATENCY-1];

endmodule
